// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and its FIFO users.
// Holds opcodes, the request-kind enum, LW/SW funct3, the ALUSel op codes used
// by CONTROLLER, and the packed request payload.
package rv_isa_pkg;

  localparam int unsigned XLEN = 32;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // funct3 values the encoder cares about
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;

  // ALUSel = {funct7[5], funct3}, identical to CONTROLLER
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    KIND_R     = 2'b00,
    KIND_I     = 2'b01,
    KIND_LOAD  = 2'b10,
    KIND_STORE = 2'b11
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } instr_req_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with push, pop, flush and occupancy count.
// Ports: clk, rst_n (async active-low), push/pop/flush, wdata in, rdata (head,
// valid when !empty), count, full, empty. Push while full and pop while empty
// are ignored; flush wins over both.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle does not free a slot for a push when full.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop_ok)  rptr <= rptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

  // Storage array, no reset needed: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes structured instruction requests into RV32I words and streams them,
// in order, to the instruction-memory write port through a small FIFO.
// Ports: clk, rst_n; request side in_valid/in_ready + in_kind/in_alu/in_rd/
// in_rs1/in_rs2/in_imm; flush; memory side imem_we/imem_ready/imem_addr/
// imem_wdata; status count (FIFO occupancy) and sticky err_illegal.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_kind,
  input  logic [3:0]                 in_alu,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [11:0]                in_imm,
  input  logic                       flush,
  output logic                       imem_we,
  input  logic                       imem_ready,
  output logic [31:0]                imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_illegal
);

  localparam logic [ADDR_W-1:0] BASE_IDX = BASE_ADDR[ADDR_W+1:2];

  // Build the machine word for one request.
  function automatic logic [XLEN-1:0] encode(input instr_req_t r);
    logic [11:0]     iimm;
    logic [XLEN-1:0] w;
    w    = '0;
    iimm = r.imm;
    case (r.kind)
      KIND_R:     w = {1'b0, r.alu[3], 5'b0, r.rs2, r.rs1, r.alu[2:0], r.rd, OPC_OP};
      KIND_I: begin
        // Shift immediates carry funct7 in the upper bits and a 5-bit shamt.
        if (r.alu[2:0] == F3_SLL || r.alu[2:0] == F3_SR)
          iimm = {1'b0, r.alu[3], 5'b0, r.imm[4:0]};
        w = {iimm, r.rs1, r.alu[2:0], r.rd, OPC_OP_IMM};
      end
      KIND_LOAD:  w = {r.imm, r.rs1, F3_LW, r.rd, OPC_LOAD};
      KIND_STORE: w = {r.imm[11:5], r.rs2, r.rs1, F3_SW, r.imm[4:0], OPC_STORE};
      default:    w = '0;
    endcase
    return w;
  endfunction

  // funct7[5] is only meaningful for sub/sra (R) and srai (I).
  function automatic logic is_legal(input instr_req_t r);
    logic ok;
    ok = 1'b1;
    case (r.kind)
      KIND_R:  ok = !(r.alu[3] && r.alu[2:0] != F3_ADD && r.alu[2:0] != F3_SR);
      KIND_I:  ok = !(r.alu[3] && r.alu[2:0] != F3_SR);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  instr_req_t        req;
  logic              accept;
  logic              legal;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] widx;

  assign req      = '{kind: kind_e'(in_kind), alu: in_alu, rd: in_rd,
                      rs1: in_rs1, rs2: in_rs2, imm: in_imm};
  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign legal    = is_legal(req);
  assign push     = accept && legal;
  assign imem_we  = !fifo_empty;
  assign pop      = imem_we && imem_ready;

  assign imem_wdata = fifo_empty ? '0 : head;
  assign imem_addr  = 32'({widx, 2'b00});

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (encode(req)),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Word-index address counter; wraps modulo 2^ADDR_W words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     widx <= BASE_IDX;
    else if (flush) widx <= BASE_IDX;
    else if (pop)   widx <= widx + ADDR_W'(1);
  end

  // Sticky illegal-request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_illegal <= 1'b0;
    else if (flush)              err_illegal <= 1'b0;
    else if (accept && !legal)   err_illegal <= 1'b1;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Converts structured instruction requests (kind, ALU op, registers, immediate) into RV32I machine words and writes them, in order, into instruction memory. It is the encoding counterpart of `CONTROLLER`: every word it emits must decode back to the same `ALUSel`, `ImmSel`, `BSel`, `MemRW`, `WBSel` and `RegWEn`. It sits between the program loader / test sequencer and the instruction-memory write port, and buffers requests in a small FIFO so the producer is decoupled from memory back-pressure.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `ADDR_W`, 10: instruction-memory word-address width. Addresses wrap modulo 2^ADDR_W words.
- `BASE_ADDR`, 32'h0: byte address of the first write. Must be word aligned.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_kind` in 2: 00 R-ALU, 01 I-ALU, 10 LOAD (lw), 11 STORE (sw).
- `in_alu` in 4: ALU op in `ALUSel` encoding `{funct7[5], funct3}`. Ignored for LOAD and STORE.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_imm` in 12: signed immediate. For shifts, only bits [4:0] are used.
- `flush` in 1: synchronous clear of the FIFO, address and error flag.
- `imem_we` out 1: write request, held until accepted.
- `imem_ready` in 1: memory accepts the write when `imem_we && imem_ready`.
- `imem_addr` out 32: byte address of the current write.
- `imem_wdata` out 32: encoded word.
- `count` out $clog2(DEPTH+1): FIFO occupancy.
- `err_illegal` out 1: sticky illegal-request flag.

## Operation
- Encoding formats:
  - R: `{0,alu[3],00000, rs2, rs1, alu[2:0], rd, 0110011}`.
  - I-ALU: `{imm, rs1, alu[2:0], rd, 0010011}`. When funct3 is 001 or 101, the immediate field becomes `{0,alu[3],00000, imm[4:0]}`.
  - LOAD: `{imm, rs1, 010, rd, 0000011}`.
  - STORE: `{imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}`.
- Illegal requests:
  - R with `alu[3]=1` and funct3 not 000 or 101.
  - I-ALU with `alu[3]=1` and funct3 not 101.
  - Illegal requests are handshaken normally (`in_ready` obeyed), are not pushed, and set `err_illegal`.
- Encoding is combinational at accept. The encoded word is pushed into the FIFO in the same edge.
- `imem_we` = FIFO not empty. `imem_wdata` = head entry, or 32'h0 when empty.
- On each `imem_we && imem_ready`: pop the head and advance `imem_addr` by 4. The word index wraps modulo 2^ADDR_W, relative to address 0, not BASE_ADDR.
- `flush` has priority over push and pop in the same cycle. The concurrent push and pop are discarded, `count` becomes 0, `imem_addr` becomes BASE_ADDR, and `err_illegal` clears.
- Reset values: `in_ready`=1, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `count`=0, `err_illegal`=0. FIFO pointers return to 0.
- Reset asserted mid-transfer: the outstanding write is abandoned with no partial state. `imem_we` drops immediately (asynchronously).

## Timing
- `in_ready` = (`count` < DEPTH). It is registered-state only, with no combinational path from `imem_ready`. When full, a same-cycle pop does not enable a push.
- Latency: a request accepted at edge N produces `imem_we`=1 with its word during cycle N+1 at the earliest, when the FIFO was empty.
- Throughput: 1 word per cycle sustained while `imem_ready`=1.
- Simultaneous push and pop when not full: `count` is unchanged and order is preserved.
- `imem_addr` and `imem_wdata` must stay stable while `imem_we`=1 and `imem_ready`=0.
- `err_illegal` is set at the edge following the illegal accept.

## Structure
- Package `rv_isa_pkg`:
  - opcode constants (OP 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011);
  - `in_kind` enum;
  - funct3 for LW and SW (010);
  - ALU op codes shared with `CONTROLLER`.
- Sub-module `instr_fifo`: a synchronous FIFO of parameter DEPTH × 32, with push, pop, flush and count.
- The encoder function and address counter live in `instr_encoder`.

## Test plan
- Encode each of the four reference instructions back-to-back with `imem_ready`=1 and BASE 0:
  - addi x1,x0,3 → 32'h00300093 @0;
  - add x3,x1,x2 → 32'h002081B3 @4;
  - sw x14,8(x2) → 32'h00E12423 @8;
  - lw x15,8(x2) → 32'h00812783 @12.
  - Feed each word to `CONTROLLER` and check that its outputs match.
- Back-pressure: hold `imem_ready`=0 and push 5 requests.
  - `in_ready` drops after 4 and `count`=4.
  - `imem_addr` and `imem_wdata` stay stable.
  - Release `imem_ready`: 4 words are written in order, then the fifth.
- Shifts and sub:
  - srai x5,x6,3 → 32'h40335293.
  - sub x1,x2,x3 → 32'h403100B3.
  - Illegal R alu=4'b1001 → no write, `err_illegal`=1.
  - `flush` → `err_illegal`=0.
- Wrap: ADDR_W=2, BASE 32'h8, 3 writes → addresses 8, 12, 0.
- `flush` in the same cycle as a push and a pop at `count`=2 → `count`=0, `imem_addr`=BASE_ADDR, and neither word appears afterwards.
- Assert `rst_n` while `imem_we`=1 → all outputs take their reset values immediately, and the next accepted request is written at BASE_ADDR.
